// File: rtl/instruction_decode_pkg.sv
// ============================================================================
//  Module  : instruction_decode_pkg
//  Brief   : RV32I opcodes, ID/EX control-word layout and ALU-op codes shared
//            by the instruction decode stage.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package instruction_decode_pkg;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [2:0] c_F3_SR     = 3'b101;

    localparam logic [1:0] c_ALUOP_MEM  = 2'b00;
    localparam logic [1:0] c_ALUOP_BR   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNC = 2'b10;

    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_F7B5     = 0;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] aluop;
        logic       f7b5;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/instruction_decode_reg_file.sv
// ============================================================================
//  Module  : instruction_decode_reg_file
//  Brief   : 2-read / 1-write register file, x0 hardwired to zero.
//            RF_BYPASS_EN: a same-cycle write is forwarded to the read ports.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instruction_decode_reg_file #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [RA_W-1:0] i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [RA_W-1:0] i_ra1,
    input  logic [RA_W-1:0] i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    localparam int NREG = 1 << RA_W;

    logic [XLEN-1:0] r_regs [0:NREG-1];
    logic            w_wr;

    assign w_wr = i_we && (i_wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    always_comb begin
        o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
        o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
`ifdef RF_BYPASS_EN
        if (w_wr && (i_wa == i_ra1)) o_rd1 = i_wd;
        if (w_wr && (i_wa == i_ra2)) o_rd2 = i_wd;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/instruction_decode.sv
// ============================================================================
//  Module  : instruction_decode
//  Brief   : RV32I ID stage: decode, immediate generation, load-use hazard
//            detection and the ID/EX pipeline register. RF_BYPASS_EN selects
//            write-before-read register file behaviour.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 8,
    parameter int RA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       IFID,
    input  logic [PC_W-1:0]   IFID_PC,
    input  logic              PCSelect,
    input  logic              wb_we,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              stall,
    output logic [PC_W-1:0]   IDEX_PC,
    output logic [XLEN-1:0]   IDEX_rs1d,
    output logic [XLEN-1:0]   IDEX_rs2d,
    output logic [XLEN-1:0]   IDEX_imm,
    output logic [RA_W-1:0]   IDEX_rs1,
    output logic [RA_W-1:0]   IDEX_rs2,
    output logic [RA_W-1:0]   IDEX_rd,
    output logic [2:0]        IDEX_funct3,
    output logic [CTRL_W-1:0] IDEX_ctrl,
    output logic              ill_ins
);

    logic [6:0]        w_opcode;
    logic [RA_W-1:0]   w_rs1;
    logic [RA_W-1:0]   w_rs2;
    logic [RA_W-1:0]   w_rd;
    logic [2:0]        w_funct3;
    logic [XLEN-1:0]   w_rs1d;
    logic [XLEN-1:0]   w_rs2d;
    ctrl_t             w_ctrl;
    logic [XLEN-1:0]   w_imm;
    logic              w_legal;
    logic              w_uses_rs2;
    logic              w_ill;
    logic              w_issue;
    logic              w_latch;

    logic [PC_W-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1d;
    logic [XLEN-1:0]   r_rs2d;
    logic [XLEN-1:0]   r_imm;
    logic [RA_W-1:0]   r_rs1;
    logic [RA_W-1:0]   r_rs2;
    logic [RA_W-1:0]   r_rd;
    logic [2:0]        r_funct3;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_ill;

    assign w_opcode = IFID[6:0];
    assign w_rd     = IFID[11:7];
    assign w_funct3 = IFID[14:12];
    assign w_rs1    = IFID[19:15];
    assign w_rs2    = IFID[24:20];

    instruction_decode_reg_file #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_we  (wb_we),
        .i_wa  (wb_rd),
        .i_wd  (wb_data),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rs1d),
        .o_rd2 (w_rs2d)
    );

    always_comb begin
        w_ctrl     = '0;
        w_imm      = '0;
        w_legal    = 1'b0;
        w_uses_rs2 = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_legal         = 1'b1;
                w_uses_rs2      = 1'b1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.aluop    = c_ALUOP_FUNC;
                w_ctrl.f7b5     = IFID[30];
            end
            c_OP_IALU: begin
                w_legal         = 1'b1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.aluop    = c_ALUOP_FUNC;
                // only SRAI carries a meaningful funct7[5]; SLLI/SRLI and the rest ignore it
                w_ctrl.f7b5     = (w_funct3 == c_F3_SR) && IFID[30];
                w_imm           = {{(XLEN-12){IFID[31]}}, IFID[31:20]};
            end
            c_OP_LOAD: begin
                w_legal         = 1'b1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.memread  = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.aluop    = c_ALUOP_MEM;
                w_imm           = {{(XLEN-12){IFID[31]}}, IFID[31:20]};
            end
            c_OP_STORE: begin
                w_legal         = 1'b1;
                w_uses_rs2      = 1'b1;
                w_ctrl.memwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.aluop    = c_ALUOP_MEM;
                w_imm           = {{(XLEN-12){IFID[31]}}, IFID[31:25], IFID[11:7]};
            end
            c_OP_BRANCH: begin
                w_legal         = 1'b1;
                w_uses_rs2      = 1'b1;
                w_ctrl.branch   = 1'b1;
                w_ctrl.aluop    = c_ALUOP_BR;
                w_imm           = {{(XLEN-12){IFID[31]}}, IFID[7], IFID[30:25],
                                   IFID[11:8], 1'b0};
            end
            default: ;
        endcase
    end

    // the all-zero word is the fetch-side NOP and must not raise ill_ins
    assign w_ill   = !w_legal && (IFID != '0);

    assign stall   = r_ctrl[CTRL_MEMREAD] && (r_rd != '0) &&
                     ((r_rd == w_rs1) || ((r_rd == w_rs2) && w_uses_rs2));

    assign w_issue = start && !PCSelect && !stall;
    assign w_latch = w_issue && w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_rs1d   <= '0;
            r_rs2d   <= '0;
            r_imm    <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_funct3 <= '0;
            r_ctrl   <= '0;
            r_ill    <= 1'b0;
        end else begin
            r_ill <= w_issue && w_ill;
            if (w_latch) begin
                r_pc     <= IFID_PC;
                r_rs1d   <= w_rs1d;
                r_rs2d   <= w_rs2d;
                r_imm    <= w_imm;
                r_rs1    <= w_rs1;
                r_rs2    <= w_rs2;
                r_rd     <= w_rd;
                r_funct3 <= w_funct3;
                r_ctrl   <= w_ctrl;
            end else begin
                r_pc     <= '0;
                r_rs1d   <= '0;
                r_rs2d   <= '0;
                r_imm    <= '0;
                r_rs1    <= '0;
                r_rs2    <= '0;
                r_rd     <= '0;
                r_funct3 <= '0;
                r_ctrl   <= '0;
            end
        end
    end

    assign IDEX_PC     = r_pc;
    assign IDEX_rs1d   = r_rs1d;
    assign IDEX_rs2d   = r_rs2d;
    assign IDEX_imm    = r_imm;
    assign IDEX_rs1    = r_rs1;
    assign IDEX_rs2    = r_rs2;
    assign IDEX_rd     = r_rd;
    assign IDEX_funct3 = r_funct3;
    assign IDEX_ctrl   = r_ctrl;
    assign ill_ins     = r_ill;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// ============================================================================
//  Module  : tb_instruction_decode
//  Brief   : Scoreboard bench for instruction_decode with a reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_decode;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                           OP_L = 7'b0000011, OP_S = 7'b0100011,
                           OP_B = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst, start, PCSelect, wb_we;
    logic [31:0] IFID, wb_data;
    logic [7:0]  IFID_PC;
    logic [4:0]  wb_rd;
    logic        stall, ill_ins;
    logic [7:0]  IDEX_PC;
    logic [31:0] IDEX_rs1d, IDEX_rs2d, IDEX_imm;
    logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [2:0]  IDEX_funct3;
    logic [8:0]  IDEX_ctrl;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst(rst), .start(start), .IFID(IFID), .IFID_PC(IFID_PC),
        .PCSelect(PCSelect), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .IDEX_PC(IDEX_PC), .IDEX_rs1d(IDEX_rs1d),
        .IDEX_rs2d(IDEX_rs2d), .IDEX_imm(IDEX_imm), .IDEX_rs1(IDEX_rs1),
        .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd), .IDEX_funct3(IDEX_funct3),
        .IDEX_ctrl(IDEX_ctrl), .ill_ins(ill_ins)
    );

    typedef struct packed {
        logic        stall;
        logic [7:0]  pc;
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [8:0]  ctrl;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [31:0] rf [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (we && wa != 5'd0 && wa == a) return wd;
`endif
        return rf[a];
    endfunction

    // Drives one cycle of stimulus and queues what the DUT must show for it.
    task automatic step(input logic r, input logic s, input logic [31:0] ins,
                        input logic [7:0] pc, input logic ps, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e, d;
        logic [6:0]  op;
        logic        legal, rs2_used;
        @(posedge clk);
        #2;
        rst = r; start = s; IFID = ins; IFID_PC = pc; PCSelect = ps;
        wb_we = we; wb_rd = wa; wb_data = wd;

        op       = ins[6:0];
        rs2_used = (op == OP_R) || (op == OP_S) || (op == OP_B);
        e        = '0;
        e.stall  = cur.ctrl[6] && (cur.rd != 5'd0) &&
                   ((cur.rd == ins[19:15]) || ((cur.rd == ins[24:20]) && rs2_used));

        d = '0; legal = 1'b1;
        d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
        d.f3 = ins[14:12];
        d.rs1d = rf_read(ins[19:15], we, wa, wd);
        d.rs2d = rf_read(ins[24:20], we, wa, wd);
        case (op)
            OP_R: d.ctrl = {6'b100000, 2'b10, ins[30]};
            OP_I: begin
                d.ctrl = {6'b100001, 2'b10, (ins[14:12] == 3'd5) ? ins[30] : 1'b0};
                d.imm  = 32'($signed(ins[31:20]));
            end
            OP_L: begin
                d.ctrl = {6'b111001, 2'b00, 1'b0};
                d.imm  = 32'($signed(ins[31:20]));
            end
            OP_S: begin
                d.ctrl = {6'b000101, 2'b00, 1'b0};
                d.imm  = 32'($signed({ins[31:25], ins[11:7]}));
            end
            OP_B: begin
                d.ctrl = {6'b000010, 2'b01, 1'b0};
                d.imm  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            default: legal = 1'b0;
        endcase

        if (!r && s && !ps && !e.stall) begin
            if (legal) e = {e.stall, d[$bits(exp_t)-2:0]};
            else       e.ill = (ins != 32'd0);
        end

        if (r) begin
            for (int k = 0; k < 32; k++) rf[k] = 32'd0;
        end else if (we && wa != 5'd0) begin
            rf[wa] = wd;
        end
        cur = e;
        q.push_back(e);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] ins;
        logic [6:0]  op;
        int          k;
        ins = $urandom();
        k   = $urandom_range(0, 9);
        case (k)
            0, 1:    op = OP_R;
            2, 3:    op = OP_I;
            4, 5:    op = OP_L;
            6:       op = OP_S;
            7:       op = OP_B;
            8:       return 32'd0;
            default: begin
                op = 7'($urandom());
                if (op == OP_R || op == OP_I || op == OP_L || op == OP_S || op == OP_B)
                    op = 7'b1111111;
            end
        endcase
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin : monitor
        exp_t it;
        forever begin
            while (q.size() == 0) #1;
            it = q.pop_front();
            @(negedge clk);
            check("stall", 32'(stall), 32'(it.stall));
            @(posedge clk);
            #1;
            check("IDEX_PC",     32'(IDEX_PC),     32'(it.pc));
            check("IDEX_rs1d",   IDEX_rs1d,        it.rs1d);
            check("IDEX_rs2d",   IDEX_rs2d,        it.rs2d);
            check("IDEX_imm",    IDEX_imm,         it.imm);
            check("IDEX_rs1",    32'(IDEX_rs1),    32'(it.rs1));
            check("IDEX_rs2",    32'(IDEX_rs2),    32'(it.rs2));
            check("IDEX_rd",     32'(IDEX_rd),     32'(it.rd));
            check("IDEX_funct3", 32'(IDEX_funct3), 32'(it.f3));
            check("IDEX_ctrl",   32'(IDEX_ctrl),   32'(it.ctrl));
            check("ill_ins",     32'(ill_ins),     32'(it.ill));
        end
    end

    initial begin : driver
        rst = 1'b1; start = 1'b0; IFID = '0; IFID_PC = '0; PCSelect = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        cur = '0;
        for (int k = 0; k < 32; k++) rf[k] = 32'd0;

        step(1, 0, 32'h0,        8'h00, 0, 0, 0, 32'h0);
        step(1, 1, 32'h0,        8'h00, 0, 1, 5, 32'h55);
        step(0, 1, 32'h00500093, 8'h04, 0, 0, 0, 32'h0);   // addi x1,x0,5
        step(0, 1, 32'h0,        8'h08, 0, 1, 1, 32'h5);   // WB x1=5
        step(0, 1, 32'h00108133, 8'h0C, 0, 0, 0, 32'h0);   // add x2,x1,x1
        step(0, 1, 32'h00002083, 8'h10, 0, 0, 0, 32'h0);   // lw x1,0(x0)
        step(0, 1, 32'h00108133, 8'h14, 0, 0, 0, 32'h0);   // load-use stall
        step(0, 1, 32'h00108133, 8'h14, 0, 0, 0, 32'h0);
        step(0, 1, 32'h003181B3, 8'h18, 1, 0, 0, 32'h0);   // flushed
        step(0, 1, 32'h00018233, 8'h1C, 0, 1, 3, 32'hA);   // read x3 during write
        step(0, 1, 32'h00018233, 8'h20, 0, 0, 0, 32'h0);
        step(0, 1, 32'hFFFFFFFF, 8'h24, 0, 0, 0, 32'h0);   // illegal
        step(0, 1, 32'h00000233, 8'h28, 0, 1, 0, 32'h7);   // write x0 dropped
        step(0, 1, 32'h00000233, 8'h2C, 0, 0, 0, 32'h0);
        step(0, 1, 32'h4051D213, 8'h30, 0, 0, 0, 32'h0);   // srai
        step(0, 1, 32'hFE112E23, 8'h34, 0, 0, 0, 32'h0);   // sw negative offset
        step(0, 1, 32'hFE208EE3, 8'h38, 0, 0, 0, 32'h0);   // beq negative offset
        step(0, 0, 32'h00108133, 8'h3C, 0, 1, 2, 32'h99);  // start low

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), rand_ins(),
                 8'($urandom()), ($urandom_range(0, 7) == 0), 1'($urandom()),
                 5'($urandom_range(0, 3)), $urandom());
        end

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
